// File: rtl/pipeline_ctrl.sv
//------------------------------------------------------------------------------
// pipeline_ctrl : hazard, redirect/trap flush and memory-wait control for a
//                 single-issue in-order pipeline.
// Revision      : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl #(
  parameter int XLEN         = 32,
  parameter int XADDR        = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic             i_ex_is_load,
  input  logic             i_ex_wr_en,
  input  logic             i_ex_redirect,
  input  logic [XLEN-1:0]  i_ex_target,
  input  logic             i_trap,
  input  logic [XLEN-1:0]  i_trap_vec,
  input  logic             i_mem_busy,
  output logic             o_stall,
  output logic             or_flush,
  output logic             or_pc_sel,
  output logic [XLEN-1:0]  or_pc_target,
  output logic [1:0]       or_state,
  output logic [15:0]      or_stall_cnt,
  output logic [15:0]      or_redir_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0]  C_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] C_CNT_MAX    = 16'hFFFF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_fcnt;
  logic [3:0]        w_fcnt_nxt;
  logic              w_pc_sel_nxt;
  logic [XLEN-1:0]   w_target_nxt;
  logic              w_stall;
  logic              w_load_use;

  assign w_load_use = i_ex_is_load & i_ex_wr_en & (i_ex_rd_addr != '0) &
                      ((i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr)) |
                       (i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr)));

  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_pc_sel_nxt = 1'b0;
    w_target_nxt = or_pc_target;
    w_stall      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_trap || i_ex_redirect) begin
          // trap wins over a same-cycle redirect
          w_state_nxt  = ST_FLUSH;
          w_fcnt_nxt   = C_FLUSH_INIT;
          w_pc_sel_nxt = 1'b1;
          w_target_nxt = i_trap ? i_trap_vec : i_ex_target;
        end else if (i_mem_busy) begin
          w_state_nxt = ST_WAIT;
          w_stall     = 1'b1;
        end else if (w_load_use) begin
          w_stall = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_stall = i_mem_busy;
        if (i_trap) begin
          w_fcnt_nxt   = C_FLUSH_INIT;
          w_pc_sel_nxt = 1'b1;
          w_target_nxt = i_trap_vec;
        end else if (!i_mem_busy) begin
          if (r_fcnt == 4'd0) w_state_nxt = ST_RUN;
          else                w_fcnt_nxt  = r_fcnt - 4'd1;
        end
      end
      ST_WAIT: begin
        w_stall = i_mem_busy;
        if (!i_mem_busy) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign o_stall  = w_stall & ~i_rst;
  assign or_state = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_fcnt       <= 4'd0;
      or_flush     <= 1'b0;
      or_pc_sel    <= 1'b0;
      or_pc_target <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fcnt       <= w_fcnt_nxt;
      or_flush     <= (w_state_nxt == ST_FLUSH);
      or_pc_sel    <= w_pc_sel_nxt;
      or_pc_target <= w_target_nxt;
    end
  end

  // redirect count advances together with the pc_sel pulse it accounts for
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      or_stall_cnt <= 16'd0;
      or_redir_cnt <= 16'd0;
    end else begin
      if (o_stall && (or_stall_cnt != C_CNT_MAX))
        or_stall_cnt <= or_stall_cnt + 16'd1;
      if (w_pc_sel_nxt && (or_redir_cnt != C_CNT_MAX))
        or_redir_cnt <= or_redir_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipeline_ctrl : scoreboard bench for pipeline_ctrl (directed + random).
// Revision         : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_ctrl;

  localparam int XLEN = 32;
  localparam int XADDR = 5;
  localparam int FC = 2;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [XADDR-1:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
  logic             i_id_uses_rs1, i_id_uses_rs2;
  logic             i_ex_is_load, i_ex_wr_en, i_ex_redirect, i_trap, i_mem_busy;
  logic [XLEN-1:0]  i_ex_target, i_trap_vec;
  logic             o_stall, or_flush, or_pc_sel;
  logic [XLEN-1:0]  or_pc_target;
  logic [1:0]       or_state;
  logic [15:0]      or_stall_cnt, or_redir_cnt;

  pipeline_ctrl #(.XLEN(XLEN), .XADDR(XADDR), .FLUSH_CYCLES(FC)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_is_load(i_ex_is_load),
    .i_ex_wr_en(i_ex_wr_en), .i_ex_redirect(i_ex_redirect),
    .i_ex_target(i_ex_target), .i_trap(i_trap), .i_trap_vec(i_trap_vec),
    .i_mem_busy(i_mem_busy), .o_stall(o_stall), .or_flush(or_flush),
    .or_pc_sel(or_pc_sel), .or_pc_target(or_pc_target), .or_state(or_state),
    .or_stall_cnt(or_stall_cnt), .or_redir_cnt(or_redir_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        pc_sel;
    logic        flush;
    logic [1:0]  state;
    logic [31:0] tgt;
    logic [15:0] scnt;
    logic [15:0] rcnt;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  m_state;
  int          m_cnt;
  logic [31:0] m_tgt;
  logic [15:0] m_scnt, m_rcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_ex_rd_addr = '0;
    i_id_uses_rs1 = 0;  i_id_uses_rs2 = 0;  i_ex_is_load = 0; i_ex_wr_en = 0;
    i_ex_redirect = 0;  i_trap = 0; i_mem_busy = 0;
    i_ex_target = '0;   i_trap_vec = '0;
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_cnt = 0; m_tgt = '0; m_scnt = '0; m_rcnt = '0;
    q.delete();
  endtask

  task automatic do_reset();
    clr();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    model_reset();
  endtask

  // One clock: predict stall now, queue predicted registered outputs, compare after the edge.
  task automatic cyc(input bit chk_en);
    logic lu, st, ps;
    exp_t e;
    #1;
    lu = i_ex_is_load && i_ex_wr_en && (i_ex_rd_addr != 0) &&
         ((i_id_uses_rs1 && i_id_rs1_addr == i_ex_rd_addr) ||
          (i_id_uses_rs2 && i_id_rs2_addr == i_ex_rd_addr));
    st = (m_state == 2'd0) ? (!i_trap && !i_ex_redirect && (i_mem_busy || lu)) : i_mem_busy;
    if (chk_en) chk("o_stall", 32'(o_stall), 32'(st));
    ps = 1'b0;
    if (m_state == 2'd0) begin
      if (i_trap || i_ex_redirect) begin
        ps = 1'b1; m_tgt = i_trap ? i_trap_vec : i_ex_target;
        m_state = 2'd1; m_cnt = FC - 1;
      end else if (i_mem_busy) m_state = 2'd2;
    end else if (m_state == 2'd1) begin
      if (i_trap) begin
        ps = 1'b1; m_tgt = i_trap_vec; m_cnt = FC - 1;
      end else if (!i_mem_busy) begin
        if (m_cnt == 0) m_state = 2'd0;
        else m_cnt--;
      end
    end else if (!i_mem_busy) m_state = 2'd0;
    if (st && m_scnt != 16'hFFFF) m_scnt++;
    if (ps && m_rcnt != 16'hFFFF) m_rcnt++;
    e = '{pc_sel: ps, flush: (m_state == 2'd1), state: m_state, tgt: m_tgt,
          scnt: m_scnt, rcnt: m_rcnt};
    q.push_back(e);
    @(posedge i_clk);
    #1;
    e = q.pop_front();
    if (chk_en) begin
      chk("pc_sel",    32'(or_pc_sel),    32'(e.pc_sel));
      chk("flush",     32'(or_flush),     32'(e.flush));
      chk("state",     32'(or_state),     32'(e.state));
      chk("pc_target", or_pc_target,      e.tgt);
      chk("stall_cnt", 32'(or_stall_cnt), 32'(e.scnt));
      chk("redir_cnt", 32'(or_redir_cnt), 32'(e.rcnt));
    end
  endtask

  initial begin
    do_reset();
    chk("rst_state", 32'(or_state), 32'd0);
    chk("rst_flush", 32'(or_flush), 32'd0);
    chk("rst_pcsel", 32'(or_pc_sel), 32'd0);
    chk("rst_tgt",   or_pc_target, 32'd0);
    chk("rst_cnts",  {or_stall_cnt, or_redir_cnt}, 32'd0);

    // load-use on rs2, then rd=0 must not stall
    i_ex_is_load = 1; i_ex_wr_en = 1; i_ex_rd_addr = 5;
    i_id_uses_rs2 = 1; i_id_rs2_addr = 5;
    cyc(1);
    chk("lu_cnt", 32'(or_stall_cnt), 32'd1);
    clr(); cyc(1);
    i_ex_is_load = 1; i_ex_wr_en = 1; i_ex_rd_addr = 0;
    i_id_uses_rs2 = 1; i_id_rs2_addr = 0;
    cyc(1);
    chk("lu_x0_cnt", 32'(or_stall_cnt), 32'd1);

    // branch redirect, two flush cycles
    clr(); i_ex_redirect = 1; i_ex_target = 32'h100;
    cyc(1);
    chk("br_pcsel", 32'(or_pc_sel), 32'd1);
    chk("br_tgt",   or_pc_target, 32'h100);
    clr();
    repeat (3) cyc(1);
    chk("br_run",   32'(or_state), 32'd0);
    chk("br_rcnt",  32'(or_redir_cnt), 32'd1);

    // trap + redirect together, then trap in second flush cycle
    i_trap = 1; i_trap_vec = 32'h80; i_ex_redirect = 1; i_ex_target = 32'h100;
    cyc(1);
    chk("tr_tgt", or_pc_target, 32'h80);
    clr(); cyc(1);
    i_trap = 1; i_trap_vec = 32'h200; cyc(1);
    chk("tr2_pcsel", 32'(or_pc_sel), 32'd1);
    clr(); repeat (4) cyc(1);

    // busy in RUN, then busy inside FLUSH
    i_mem_busy = 1; repeat (3) cyc(1);
    i_mem_busy = 0; repeat (2) cyc(1);
    i_ex_redirect = 1; i_ex_target = 32'h300; cyc(1);
    clr(); i_mem_busy = 1; repeat (2) cyc(1);
    i_mem_busy = 0; repeat (3) cyc(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      i_trap        = ($urandom_range(15) == 0);
      i_ex_redirect = ($urandom_range(5) == 0);
      i_mem_busy    = ($urandom_range(4) == 0);
      i_ex_is_load  = $urandom_range(1);
      i_ex_wr_en    = $urandom_range(1);
      i_id_uses_rs1 = $urandom_range(1);
      i_id_uses_rs2 = $urandom_range(1);
      i_ex_rd_addr  = XADDR'($urandom_range(3));
      i_id_rs1_addr = XADDR'($urandom_range(3));
      i_id_rs2_addr = XADDR'($urandom_range(3));
      i_ex_target   = $urandom;
      i_trap_vec    = $urandom;
      cyc(1);
    end

    // asynchronous reset between edges while flushing with busy high
    clr(); cyc(0); i_mem_busy = 0; repeat (3) cyc(0);
    do_reset();
    i_ex_redirect = 1; i_ex_target = 32'h400; cyc(1);
    clr(); i_mem_busy = 1;
    #2 i_rst = 1'b1;
    #1;
    chk("arst_flush", 32'(or_flush), 32'd0);
    chk("arst_pcsel", 32'(or_pc_sel), 32'd0);
    chk("arst_state", 32'(or_state), 32'd0);
    chk("arst_tgt",   or_pc_target, 32'd0);
    chk("arst_cnts",  {or_stall_cnt, or_redir_cnt}, 32'd0);
    chk("arst_stall", 32'(o_stall), 32'd0);
    #1 i_rst = 1'b0;
    model_reset();
    i_mem_busy = 0;
    repeat (3) cyc(1);

    // stall counter saturation
    i_mem_busy = 1;
    for (int i = 0; i < 65540; i++) cyc(0);
    chk("stall_sat", 32'(or_stall_cnt), 32'hFFFF);
    cyc(1);
    i_mem_busy = 0; cyc(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
